// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: pixel position, pixel request, frame/line
// markers, and hsync/vsync/de delayed to line up with pipelined pixel data.
module video_timing_gen #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0,
    parameter int unsigned PIPE_DLY  = 2,
    parameter int unsigned CW        = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ce,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          req,
    output logic          frame_start,
    output logic          line_start,
    output logic          hsync,
    output logic          vsync,
    output logic          de
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic [CW-1:0] h_cnt_q, h_cnt_d;
    logic [CW-1:0] v_cnt_q, v_cnt_d;
    logic          hs0, vs0;
    logic [2:0]    stage0;
    logic [2:0]    tap;

    // Wrap on >= so a corrupted count above the total recovers on the next ce edge.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (ce) begin
            if (h_cnt_q >= H_LAST) begin
                h_cnt_d = '0;
                if (v_cnt_q >= V_LAST) v_cnt_d = '0;
                else                   v_cnt_d = v_cnt_q + CW'(1);
            end else begin
                h_cnt_d = h_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    always_comb begin
        req         = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        frame_start = (h_cnt_q == '0) && (v_cnt_q == '0);
        line_start  = (h_cnt_q == '0);
        hs0         = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
        vs0         = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
        stage0      = {hs0, vs0, req};
        x           = h_cnt_q;
        y           = v_cnt_q;
    end

    generate
        if (PIPE_DLY == 0) begin : g_nodly
            always_comb tap = stage0;
        end else begin : g_dly
            // Packed chain: newest entry in the low bits, oldest at the top.
            logic [3*PIPE_DLY-1:0] dly_q;
            logic [3*PIPE_DLY+2:0] chain;

            always_comb chain = {dly_q, stage0};

            always_ff @(posedge clk or negedge reset) begin
                if (!reset)  dly_q <= '0;
                else if (ce) dly_q <= chain[3*PIPE_DLY-1:0];
            end

            always_comb tap = dly_q[3*PIPE_DLY-1 -: 3];
        end
    endgenerate

    always_comb begin
        hsync = tap[2] ? HSYNC_POL : ~HSYNC_POL;
        vsync = tap[1] ? VSYNC_POL : ~VSYNC_POL;
        de    = tap[0];
    end

endmodule
